// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bus between the pipeline and the multiply/divide unit
interface muldiv_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  rd;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  waddr;
    logic        regWrite;
    modport master (output start, funct3, opA, opB, rd, flush,
                    input  busy, done, result, waddr, regWrite);
    modport slave  (input  start, funct3, opA, opB, rd, flush,
                    output busy, done, result, waddr, regWrite);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per cycle after a magnitude-prep cycle
module muldiv_unit (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state, nxt;
    logic [2:0]  f3;
    logic [4:0]  cnt, waddr_q;
    logic        init, sa, sb, sa_i, sb_i, dz, ovf, special, accept;
    logic [31:0] m, res, a, b, quo, rem, fin, spec_res;
    logic [63:0] p, p_nxt, prod;
    logic [32:0] madd, sh, dif;
    // p holds the raw {opB, opA} until the prep cycle, then {hi/rem, lo/quotient}
    assign a        = p[31:0];
    assign b        = p[63:32];
    assign sa_i     = f3[2] ? (a[31] & ~f3[0]) : (a[31] & (f3[1] ^ f3[0]));
    assign sb_i     = f3[2] ? (b[31] & ~f3[0]) : (b[31] & (f3[1:0] == 2'b01));
    assign madd     = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
    assign sh       = {p[63:32], p[31]};
    assign dif      = sh - {1'b0, m};
    assign p_nxt    = f3[2] ? (dif[32] ? {sh[31:0], p[30:0], 1'b0} : {dif[31:0], p[30:0], 1'b1})
                            : {madd, p[31:1]};
    assign prod     = (sa ^ sb) ? -p_nxt : p_nxt;
    assign quo      = (sa ^ sb) ? -p_nxt[31:0] : p_nxt[31:0];
    assign rem      = sa ? -p_nxt[63:32] : p_nxt[63:32];
    assign fin      = f3[2] ? (f3[1] ? rem : quo) : (f3[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
    assign dz       = bus.funct3[2] && bus.opB == 32'd0;
    assign ovf      = bus.funct3[2] && !bus.funct3[0] && bus.opA == 32'h8000_0000 && bus.opB == 32'hFFFF_FFFF;
    assign special  = dz || ovf;
    assign spec_res = dz ? (bus.funct3[1] ? bus.opA : 32'hFFFF_FFFF) : (bus.funct3[1] ? 32'd0 : 32'h8000_0000);
    assign accept   = state == IDLE && bus.start && !bus.flush;
    assign bus.result = res;
    assign bus.waddr  = waddr_q;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = bus.flush       ? IDLE :
              state == IDLE   ? (bus.start ? (special ? DONE : CALC) : IDLE) :
              state == CALC   ? ((!init && cnt == 5'd31) ? DONE : CALC) : IDLE;
    end
    always_comb begin
        bus.busy     = state != IDLE;
        bus.done     = state == DONE;
        bus.regWrite = state == DONE && waddr_q != 5'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            f3 <= 3'd0; cnt <= 5'd0; init <= 1'b0; sa <= 1'b0; sb <= 1'b0;
            m <= 32'd0; p <= 64'd0; res <= 32'd0; waddr_q <= 5'd0;
        end else if (accept) begin
            f3 <= bus.funct3; waddr_q <= bus.rd; p <= {bus.opB, bus.opA};
            cnt <= 5'd0; init <= 1'b1;
            if (special) res <= spec_res;
        end else if (state == CALC && !bus.flush) begin
            if (init) begin
                init <= 1'b0; sa <= sa_i; sb <= sb_i;
                m <= sb_i ? -b : b;
                p <= {32'd0, sa_i ? -a : a};
            end else begin
                p <= p_nxt;
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) res <= fin;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit latency, results, flush, blocking and reset
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   total = 0, passed = 0;
    always #5 clk = ~clk;
    muldiv_if bus ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input int lat, input logic [31:0] exp);
        int n;
        @(negedge clk);
        bus.start = 1; bus.funct3 = f; bus.opA = a; bus.opB = b; bus.rd = r;
        @(posedge clk); #1;
        bus.start = 0; bus.funct3 = ~f; bus.opA = ~a; bus.opB = a; bus.rd = ~r;
        chk({tag, " busy"}, bus.busy, 1);
        wait_done(n);
        chk({tag, " latency"}, n, lat);
        chk({tag, " result"}, bus.result, exp);
        chk({tag, " waddr"}, bus.waddr, r);
        chk({tag, " regWrite"}, bus.regWrite, r != 5'd0);
        @(posedge clk); #1;
        chk({tag, " idle"}, {bus.busy, bus.done}, 0);
    endtask
    initial begin
        int n, pulses;
        rst = 1; bus.start = 0; bus.flush = 0; bus.funct3 = 0; bus.opA = 0; bus.opB = 0; bus.rd = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", {bus.busy, bus.done, bus.regWrite, bus.waddr}, 0);
        chk("reset result", bus.result, 0);
        @(negedge clk) rst = 0;
        do_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  33, 32'hFFFF_FFEB);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  33, 32'hFFFF_FFFE);
        do_op("mulh",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  33, 32'h0);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFE,  32'd3,         5'd11, 33, 32'hFFFF_FFFF);
        do_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd8,  33, 32'hFFFF_FFFD);
        do_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd9,  33, 32'hFFFF_FFFF);
        do_op("divu",   3'b101, 32'd100,        32'd7,         5'd12, 33, 32'd14);
        do_op("remu",   3'b111, 32'd100,        32'd7,         5'd13, 33, 32'd2);
        do_op("divu0",  3'b101, 32'd55,         32'd0,         5'd14, 0,  32'hFFFF_FFFF);
        do_op("rem0",   3'b110, 32'h1234,       32'd0,         5'd15, 0,  32'h1234);
        do_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 0,  32'h8000_0000);
        do_op("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 0,  32'h0);
        do_op("rd0",    3'b000, 32'd3,          32'd4,         5'd0,  33, 32'd12);
        // flush ten cycles into CALC, then restart right away
        @(negedge clk);
        bus.start = 1; bus.funct3 = 3'b000; bus.opA = 32'd5; bus.opB = 32'd6; bus.rd = 5'd3;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush pre busy", bus.busy, 1);
        @(negedge clk) bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0;
        chk("flush outs", {bus.busy, bus.done, bus.regWrite}, 0);
        do_op("after flush", 3'b000, 32'd6, 32'd7, 5'd3, 33, 32'd42);
        @(negedge clk);
        bus.start = 1; bus.flush = 1;
        @(posedge clk); #1;
        bus.start = 0; bus.flush = 0;
        chk("flush wins", bus.busy, 0);
        // start held high through the whole operation
        @(negedge clk);
        bus.start = 1; bus.funct3 = 3'b000; bus.opA = 32'd9; bus.opB = 32'd9; bus.rd = 5'd4;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                pulses++;
                bus.start = 0;
                chk("held result", bus.result, 32'd81);
            end
        end
        bus.start = 0;
        chk("held pulses", pulses, 1);
        // reset mid-CALC, then start on the first edge after release
        @(negedge clk);
        bus.start = 1; bus.funct3 = 3'b000; bus.opA = 32'd2; bus.opB = 32'd3; bus.rd = 5'd9;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        chk("rst mid outs", {bus.busy, bus.done, bus.regWrite, bus.waddr}, 0);
        chk("rst mid result", bus.result, 0);
        @(negedge clk);
        rst = 0; bus.start = 1; bus.opA = 32'd4; bus.opB = 32'd5; bus.rd = 5'd10;
        @(posedge clk); #1;
        bus.start = 0;
        chk("post rst busy", bus.busy, 1);
        wait_done(n);
        chk("post rst latency", n, 33);
        chk("post rst result", bus.result, 32'd20);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
